mips_fetch: RTL and testbench

Instruction fetch stage for the single-issue MIPS core, directly upstream of `mips_decode`. It owns the program counter, issues word reads to instruction memory over a ready/valid handshake, and holds each fetched instruction until the decode/execute side accepts it. On acceptance it selects the next PC from the decoder's `control_type` and `except` outputs. It computes branch and jump targets from the held instruction word, and takes jump-register targets from the register file.

---
 rtl/mips_fetch.sv | 103 ++++++++++
 tb/tb_mips_fetch.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_fetch.sv
// MIPS instruction fetch stage: owns the PC, fetches words from instruction memory,
// holds each instruction for decode and picks the next PC when decode accepts it.
module mips_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  input  logic        inst_ack,
  input  logic [1:0]  control_type,
  input  logic        except,
  input  logic [31:0] rs_data,
  output logic        exc_taken,
  output logic [31:0] epc,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  localparam logic [1:0] CT_SEQ    = 2'b00;
  localparam logic [1:0] CT_BRANCH = 2'b01;
  localparam logic [1:0] CT_JUMP   = 2'b10;

  logic [1:0]  state;
  logic [31:0] p4;
  logic [31:0] br_off;
  logic [31:0] target;
  logic        take_exc;

  // Handshakes: a memory request transfers on a clock edge where imem_req and
  // imem_ready are both 1; read data is taken only in WAIT on imem_rvalid; an
  // instruction transfers to decode on an edge where inst_valid and inst_ack are 1.
  // Every other combination of these inputs is ignored.
  assign imem_req   = (state == REQ);
  assign inst_valid = (state == HOLD);
  assign imem_addr  = pc;
  assign dbg_state  = state;

  always_comb begin
    p4       = pc + 32'd4;
    br_off   = {{14{inst[15]}}, inst[15:0], 2'b00};
    target   = p4;
    take_exc = except;
    case (control_type)
      CT_SEQ:    target = p4;
      CT_BRANCH: target = p4 + br_off;
      CT_JUMP:   target = {p4[31:28], inst[25:0], 2'b00};
      default: begin
        target = rs_data;
        // a misaligned register target faults like an unrecognised instruction
        if (rs_data[1:0] != 2'b00) take_exc = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      inst      <= 32'd0;
      epc       <= 32'd0;
      exc_taken <= 1'b0;
    end else begin
      exc_taken <= 1'b0;
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (imem_ready) state <= WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            inst  <= imem_rdata;
            state <= HOLD;
          end
        end
        default: begin
          if (inst_ack) begin
            state <= REQ;
            if (take_exc) begin
              pc        <= EXC_VECTOR;
              epc       <= pc;
              exc_taken <= 1'b1;
            end else begin
              pc <= target;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_fetch.sv
// Self-checking bench for mips_fetch: directed branch/jump/exception cases, stalls,
// randomized fetch streams and reset during an outstanding read.
module tb_mips_fetch;

  localparam logic [31:0] RESET_PC   = 32'h0040_0000;
  localparam logic [31:0] EXC_VECTOR = 32'h8000_0180;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic        inst_ack = 1'b0;
  logic [1:0]  control_type = 2'b00;
  logic        except = 1'b0;
  logic [31:0] rs_data = 32'd0;
  logic        exc_taken;
  logic [31:0] epc;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  logic        exp_exc = 1'b0;
  logic [31:0] exp_epc = 32'd0;

  mips_fetch #(.RESET_PC(RESET_PC), .EXC_VECTOR(EXC_VECTOR)) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst(inst), .inst_valid(inst_valid), .pc(pc),
    .inst_ack(inst_ack), .control_type(control_type), .except(except),
    .rs_data(rs_data), .exc_taken(exc_taken), .epc(epc), .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference next-PC rules, plain arithmetic on whole words.
  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] ins,
                                             input logic [1:0] ct, input logic ex,
                                             input logic [31:0] rs, output bit trap);
    logic [31:0] p4;
    int off;
    p4   = cur + 32'd4;
    trap = ex || (ct == 2'd3 && (rs % 4) != 0);
    if (trap) return EXC_VECTOR;
    case (ct)
      2'd0: return p4;
      2'd1: begin
        off = int'($signed(ins[15:0]));
        return p4 + 32'(off * 4);
      end
      2'd2: return (p4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
      default: return rs;
    endcase
  endfunction

  task automatic do_fetch(input int rstall, input int vdelay, input int astall,
                          input logic [1:0] ct, input logic ex, input logic [31:0] rs,
                          input logic [31:0] word, input bit spurious);
    logic [31:0] addr_exp;
    logic [31:0] nxt;
    bit trap;
    addr_exp = exp_q[0];
    check("req_first", 32'(imem_req), 32'd1);
    check("addr", imem_addr, addr_exp);
    check("exc_taken_pulse", 32'(exc_taken), 32'(exp_exc));
    check("epc", epc, exp_epc);
    for (int i = 0; i < rstall; i++) begin
      imem_ready  = 1'b0;
      imem_rvalid = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
      imem_rdata  = $urandom;
      tick();
      check("req_stall", 32'(imem_req), 32'd1);
      check("addr_stall", imem_addr, addr_exp);
      check("exc_taken_clr", 32'(exc_taken), 32'd0);
    end
    imem_rvalid = 1'b0;
    imem_ready  = 1'b1;
    tick();
    imem_ready = 1'b0;
    check("req_wait", 32'(imem_req), 32'd0);
    check("valid_wait", 32'(inst_valid), 32'd0);
    check("exc_taken_clr", 32'(exc_taken), 32'd0);
    for (int i = 0; i < vdelay; i++) begin
      inst_ack     = 1'($urandom_range(0, 1));
      control_type = 2'($urandom_range(0, 3));
      except       = 1'($urandom_range(0, 1));
      tick();
      check("valid_wait", 32'(inst_valid), 32'd0);
      check("addr_wait", imem_addr, addr_exp);
    end
    inst_ack     = 1'b0;
    except       = 1'b0;
    control_type = 2'd0;
    imem_rvalid  = 1'b1;
    imem_rdata   = word;
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    addr_exp = exp_q.pop_front();
    check("valid_hold", 32'(inst_valid), 32'd1);
    check("inst", inst, word);
    check("pc", pc, addr_exp);
    for (int i = 0; i < astall; i++) begin
      imem_rvalid = spurious;
      tick();
      imem_rvalid = 1'b0;
      check("valid_hold", 32'(inst_valid), 32'd1);
      check("inst_stable", inst, word);
      check("pc_stable", pc, addr_exp);
      check("req_hold", 32'(imem_req), 32'd0);
    end
    nxt = model_next(addr_exp, word, ct, ex, rs, trap);
    inst_ack     = 1'b1;
    control_type = ct;
    except       = ex;
    rs_data      = rs;
    tick();
    inst_ack     = 1'b0;
    except       = 1'b0;
    control_type = 2'd0;
    rs_data      = $urandom;
    check("valid_drop", 32'(inst_valid), 32'd0);
    exp_q.push_back(nxt);
    exp_exc = trap;
    if (trap) exp_epc = addr_exp;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req"}, 32'(imem_req), 32'd0);
    check({tag, "_valid"}, 32'(inst_valid), 32'd0);
    check({tag, "_exc"}, 32'(exc_taken), 32'd0);
    check({tag, "_pc"}, pc, RESET_PC);
    check({tag, "_addr"}, imem_addr, RESET_PC);
    check({tag, "_inst"}, inst, 32'd0);
    check({tag, "_epc"}, epc, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] word;
    logic [31:0] rs;
    #12;
    check_reset_values("reset");
    reset = 1'b1;
    check("idle_no_req", 32'(imem_req), 32'd0);
    tick();
    exp_q.push_back(RESET_PC);

    // directed next-PC cases
    do_fetch(0, 0, 0, 2'd0, 1'b0, 32'd0, 32'h2008_0005, 1'b0);
    check("seq_next", exp_q[0], 32'h0040_0004);
    do_fetch(0, 0, 0, 2'd3, 1'b0, 32'h0040_0010, 32'h0000_0008, 1'b0);
    do_fetch(0, 0, 0, 2'd1, 1'b0, 32'd0, 32'h1000_FFFC, 1'b0);
    do_fetch(0, 0, 0, 2'd3, 1'b0, 32'h0040_0010, 32'h0000_0008, 1'b0);
    do_fetch(0, 0, 0, 2'd1, 1'b0, 32'd0, 32'h1000_0003, 1'b0);
    do_fetch(0, 0, 0, 2'd3, 1'b0, 32'h0040_0000, 32'h0000_0008, 1'b0);
    do_fetch(0, 0, 0, 2'd2, 1'b0, 32'd0, 32'h0810_0008, 1'b0);
    do_fetch(0, 0, 0, 2'd3, 1'b0, 32'h0040_0100, 32'h0000_0008, 1'b0);
    do_fetch(0, 0, 0, 2'd3, 1'b0, 32'h0040_0008, 32'h0000_0008, 1'b0);
    do_fetch(0, 0, 0, 2'd2, 1'b1, 32'd0, 32'h0810_0008, 1'b0);
    do_fetch(0, 0, 0, 2'd3, 1'b0, 32'h0040_0102, 32'h0000_0008, 1'b0);
    do_fetch(0, 0, 0, 2'd0, 1'b0, 32'd0, 32'h0000_0000, 1'b0);

    // long stalls with spurious read data while holding
    do_fetch(5, 3, 10, 2'd0, 1'b0, 32'd0, 32'h1234_5678, 1'b1);

    for (int n = 0; n < 60; n++) begin
      word = $urandom;
      rs   = ($urandom_range(0, 5) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      do_fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               2'($urandom_range(0, 3)), 1'($urandom_range(0, 7) == 0), rs, word,
               1'($urandom_range(0, 1)));
    end

    // reset while a read is outstanding
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    check("mid_wait_state_req", 32'(imem_req), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    check_reset_values("async_reset");
    @(posedge clock);
    #1;
    reset       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    check("late_rvalid_valid", 32'(inst_valid), 32'd0);
    check("late_rvalid_inst", inst, 32'd0);
    check("restart_req", 32'(imem_req), 32'd1);
    check("restart_addr", imem_addr, RESET_PC);
    exp_q.delete();
    exp_q.push_back(RESET_PC);
    exp_exc = 1'b0;
    exp_epc = 32'd0;
    do_fetch(1, 1, 1, 2'd0, 1'b0, 32'd0, 32'hCAFE_0001, 1'b0);
    check("restart_next", imem_addr, 32'h0040_0004);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
